icg_enable_ctrl: RTL

//  Generates the E input of a positive-edge integrated clock gate (icgtp_*), the

---
 rtl/icg_ctrl_pkg.sv | 27 ++
 rtl/icg_enable_ctrl_if.sv | 33 +++
 rtl/icg_ctrl_cnt.sv | 42 ++++
 rtl/icg_enable_ctrl.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/icg_ctrl_pkg.sv
// Shared types and constants for the clock-gate enable controller:
// FSM state encoding, output reset values and parameter helpers.
package icg_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_IDLE  = 2'b01,
        ST_GATED = 2'b10,
        ST_WAKE  = 2'b11
    } icg_state_e;

    localparam logic E_RST        = 1'b1;
    localparam logic GATED_RST    = 1'b0;
    localparam logic WAKE_ACK_RST = 1'b0;

    function automatic bit cycles_legal(input int cycles);
        return (cycles >= 32'sd1);
    endfunction

    // Counter must hold the larger of the two reload values plus one.
    function automatic int cnt_width(input int idle_cycles, input int wake_cycles);
        int max_v;
        max_v = (idle_cycles > wake_cycles) ? idle_cycles : wake_cycles;
        return $clog2(max_v + 32'sd1);
    endfunction

endpackage

// File: rtl/icg_enable_ctrl_if.sv
// Request/status bundle between the gated-domain requester and the
// ICG enable controller.
interface icg_enable_ctrl_if;

    logic SLEEP_EN;
    logic ACTIVE;
    logic WAKE_REQ;
    logic TE;
    logic E;
    logic GATED;
    logic WAKE_ACK;

    modport master (
        output SLEEP_EN,
        output ACTIVE,
        output WAKE_REQ,
        output TE,
        input  E,
        input  GATED,
        input  WAKE_ACK
    );

    modport slave (
        input  SLEEP_EN,
        input  ACTIVE,
        input  WAKE_REQ,
        input  TE,
        output E,
        output GATED,
        output WAKE_ACK
    );

endinterface

// File: rtl/icg_ctrl_cnt.sv
// Loadable down-counter with zero flag; saturates at zero so a stray
// decrement cannot wrap into a long idle window.
module icg_ctrl_cnt #(
    parameter int WIDTH = 5
) (
    input  logic             CLK,
    input  logic             RN,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             dec_i,
    output logic [WIDTH-1:0] cnt_o,
    output logic             zero_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // Next count: load has priority over decrement.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != {WIDTH{1'b0}})) begin
            cnt_d = cnt_q - {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            cnt_q <= {WIDTH{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign zero_o = (cnt_q == {WIDTH{1'b0}});

endmodule

// File: rtl/icg_enable_ctrl.sv
// Drives the E pin of a positive-edge ICG: drops E after an idle window,
// restores it on activity/wake/scan and acknowledges restoration.
module icg_enable_ctrl
    import icg_ctrl_pkg::*;
#(
    parameter int IDLE_CYCLES = 16,
    parameter int WAKE_CYCLES = 2
) (
    input  logic CLK,
    input  logic RN,
    icg_enable_ctrl_if.slave bus
);

    localparam int CNT_W = cnt_width(IDLE_CYCLES, WAKE_CYCLES);
    localparam logic [CNT_W-1:0] IDLE_LOAD = CNT_W'(IDLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAKE_LOAD = CNT_W'(WAKE_CYCLES - 1);

    if (!cycles_legal(IDLE_CYCLES)) begin : g_bad_idle
        $error("icg_enable_ctrl: IDLE_CYCLES must be >= 1");
    end
    if (!cycles_legal(WAKE_CYCLES)) begin : g_bad_wake
        $error("icg_enable_ctrl: WAKE_CYCLES must be >= 1");
    end

    icg_state_e       state_q;
    logic             e_q;
    logic             gated_q;
    logic             wake_ack_q;

    logic             wake_s;
    logic             load_s;
    logic [CNT_W-1:0] load_val_s;
    logic             dec_s;
    logic [CNT_W-1:0] cnt_s;
    logic             cnt_zero_s;

    assign wake_s = bus.ACTIVE | bus.WAKE_REQ | ~bus.SLEEP_EN | bus.TE;

    // Counter control: reload on entering IDLE/WAKE, count down while waiting.
    always_comb begin
        load_s     = 1'b0;
        load_val_s = {CNT_W{1'b0}};
        dec_s      = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (!wake_s) begin
                    load_s     = 1'b1;
                    load_val_s = IDLE_LOAD;
                end else begin
                    load_s = 1'b0;
                end
            end
            ST_IDLE: begin
                if (!wake_s && (cnt_s != {CNT_W{1'b0}})) begin
                    dec_s = 1'b1;
                end else begin
                    dec_s = 1'b0;
                end
            end
            ST_GATED: begin
                if (wake_s) begin
                    load_s     = 1'b1;
                    load_val_s = WAKE_LOAD;
                end else begin
                    load_s = 1'b0;
                end
            end
            ST_WAKE: begin
                if (!cnt_zero_s) begin
                    dec_s = 1'b1;
                end else begin
                    dec_s = 1'b0;
                end
            end
            default: begin
                load_s = 1'b0;
                dec_s  = 1'b0;
            end
        endcase
    end

    icg_ctrl_cnt #(
        .WIDTH (CNT_W)
    ) u_cnt (
        .CLK        (CLK),
        .RN         (RN),
        .load_i     (load_s),
        .load_val_i (load_val_s),
        .dec_i      (dec_s),
        .cnt_o      (cnt_s),
        .zero_o     (cnt_zero_s)
    );

    // State and all outputs are registered together so E is a pure flop output.
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state_q    <= ST_RUN;
            e_q        <= E_RST;
            gated_q    <= GATED_RST;
            wake_ack_q <= WAKE_ACK_RST;
        end else begin
            wake_ack_q <= 1'b0;
            case (state_q)
                ST_RUN: begin
                    e_q     <= 1'b1;
                    gated_q <= 1'b0;
                    if (!wake_s) begin
                        state_q <= ST_IDLE;
                    end else begin
                        state_q <= ST_RUN;
                    end
                end
                ST_IDLE: begin
                    if (wake_s) begin
                        state_q <= ST_RUN;
                        e_q     <= 1'b1;
                        gated_q <= 1'b0;
                    end else if (cnt_zero_s) begin
                        state_q <= ST_GATED;
                        e_q     <= 1'b0;
                        gated_q <= 1'b1;
                    end else begin
                        state_q <= ST_IDLE;
                        e_q     <= 1'b1;
                        gated_q <= 1'b0;
                    end
                end
                ST_GATED: begin
                    if (wake_s) begin
                        state_q <= ST_WAKE;
                        e_q     <= 1'b1;
                        gated_q <= 1'b0;
                    end else begin
                        state_q <= ST_GATED;
                        e_q     <= 1'b0;
                        gated_q <= 1'b1;
                    end
                end
                ST_WAKE: begin
                    e_q     <= 1'b1;
                    gated_q <= 1'b0;
                    if (cnt_zero_s) begin
                        state_q    <= ST_RUN;
                        wake_ack_q <= 1'b1;
                    end else begin
                        state_q <= ST_WAKE;
                    end
                end
                default: begin
                    state_q <= ST_RUN;
                    e_q     <= 1'b1;
                    gated_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.E        = e_q;
    assign bus.GATED    = gated_q;
    assign bus.WAKE_ACK = wake_ack_q;

endmodule
